// File: rtl/fp_pkg.sv
// Shared constants, state encoding and unpacked-operand type for the
// sequential single-precision adder.
package fp_pkg;

    localparam int          EXP_W    = 8;
    localparam int          MAN_W    = 23;
    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'd255;
    localparam logic [31:0] QNAN     = 32'h7FC00000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic               sign;
        logic [EXP_W-1:0]   exp;
        logic [MAN_W:0]     sig;
    } fp_op_t;

    // Exponent 0 is treated as zero, so denormals lose their fraction here.
    // flip_sign turns a+b into a-b by inverting the operand's sign.
    function automatic fp_op_t fp_unpack(input logic [31:0] v, input logic flip_sign);
        fp_op_t o;
        o.sign = v[31] ^ flip_sign;
        o.exp  = v[30:23];
        o.sig  = (v[30:23] == '0) ? '0 : {1'b1, v[22:0]};
        return o;
    endfunction

endpackage

// File: rtl/fp_align.sv
// Exponent compare and clamped right shift of the smaller operand.
module fp_align
    import fp_pkg::*;
#(
    parameter int MAX_SHIFT = 24
) (
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic [MAN_W:0]   sig_a,
    input  logic [MAN_W:0]   sig_b,
    output logic [EXP_W-1:0] exp_w,
    output logic [MAN_W:0]   sig_a_al,
    output logic [MAN_W:0]   sig_b_al
);

    localparam logic [8:0] MAX_SH = 9'(MAX_SHIFT);

    logic             a_ge;
    logic [EXP_W-1:0] diff;
    logic             clamp;

    // Larger exponent wins; the other significand is shifted right, or
    // zeroed outright once the difference reaches the clamp.
    always_comb begin
        a_ge     = (exp_a >= exp_b);
        diff     = a_ge ? (exp_a - exp_b) : (exp_b - exp_a);
        clamp    = ({1'b0, diff} >= MAX_SH);
        exp_w    = a_ge ? exp_a : exp_b;
        sig_a_al = sig_a;
        sig_b_al = sig_b;
        if (a_ge) begin
            sig_b_al = clamp ? '0 : (sig_b >> diff);
        end else begin
            sig_a_al = clamp ? '0 : (sig_a >> diff);
        end
    end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle binary32 adder/subtractor: one shared align/add/normalize
// datapath sequenced by a small FSM, valid/ready on both sides.
//
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready high
//   ALIGN | align smaller significand to the larger exponent
//   ADD   | add/subtract significands, or resolve NaN/inf/zero specials
//   NORM  | one normalization step per cycle until normalized
//   DONE  | packed result held on result until out_ready
module fp_add_seq
    import fp_pkg::*;
#(
    parameter int MAX_SHIFT = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    state_t state, state_nx;

    fp_op_t           op_a, op_b;
    logic [EXP_W-1:0] exp_r;
    logic [MAN_W:0]   sig_a_r, sig_b_r;
    logic [MAN_W+1:0] sum_r;
    logic             sign_r;

    logic [EXP_W-1:0] al_exp;
    logic [MAN_W:0]   al_sig_a, al_sig_b;

    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             special;
    logic [31:0]      special_val;
    logic             a_mag_ge, mag_eq;
    logic [MAN_W+1:0] add_sum;
    logic             add_sign;

    logic             norm_done;
    logic [31:0]      norm_res;

    fp_align #(.MAX_SHIFT(MAX_SHIFT)) u_align (
        .exp_a    (op_a.exp),
        .exp_b    (op_b.exp),
        .sig_a    (op_a.sig),
        .sig_b    (op_b.sig),
        .exp_w    (al_exp),
        .sig_a_al (al_sig_a),
        .sig_b_al (al_sig_b)
    );

    // Special-case detection and significand add/subtract used in ADD.
    always_comb begin
        a_nan  = (op_a.exp == EXP_MAX) && (op_a.sig[MAN_W-1:0] != '0);
        b_nan  = (op_b.exp == EXP_MAX) && (op_b.sig[MAN_W-1:0] != '0);
        a_inf  = (op_a.exp == EXP_MAX) && (op_a.sig[MAN_W-1:0] == '0);
        b_inf  = (op_b.exp == EXP_MAX) && (op_b.sig[MAN_W-1:0] == '0);
        a_zero = (op_a.exp == '0);
        b_zero = (op_b.exp == '0);

        special     = a_nan | b_nan | a_inf | b_inf | (a_zero & b_zero);
        special_val = {op_a.sign & op_b.sign, 31'd0};
        if (a_nan || b_nan || (a_inf && b_inf && (op_a.sign != op_b.sign))) begin
            special_val = QNAN;
        end else if (a_inf) begin
            special_val = {op_a.sign, EXP_MAX, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            special_val = {op_b.sign, EXP_MAX, {MAN_W{1'b0}}};
        end

        mag_eq   = (op_a.exp == op_b.exp) && (op_a.sig == op_b.sig);
        a_mag_ge = (op_a.exp > op_b.exp) ||
                   ((op_a.exp == op_b.exp) && (op_a.sig >= op_b.sig));

        if (op_a.sign == op_b.sign) begin
            add_sum  = {1'b0, sig_a_r} + {1'b0, sig_b_r};
            add_sign = op_a.sign;
        end else if (a_mag_ge) begin
            add_sum  = {1'b0, sig_a_r} - {1'b0, sig_b_r};
            add_sign = mag_eq ? 1'b0 : op_a.sign;
        end else begin
            add_sum  = {1'b0, sig_b_r} - {1'b0, sig_a_r};
            add_sign = op_b.sign;
        end
    end

    // One normalization decision per cycle; exits pack the result directly.
    always_comb begin
        norm_done = 1'b1;
        norm_res  = '0;
        if (sum_r[MAN_W+1]) begin
            if (exp_r == (EXP_MAX - 8'd1)) begin
                norm_res = {sign_r, EXP_MAX, {MAN_W{1'b0}}};
            end else begin
                norm_res = {sign_r, exp_r + 8'd1, sum_r[MAN_W:1]};
            end
        end else if (sum_r[MAN_W]) begin
            norm_res = {sign_r, exp_r, sum_r[MAN_W-1:0]};
        end else if (sum_r == '0) begin
            norm_res = '0;
        end else if (exp_r == 8'd1) begin
            norm_res = {sign_r, 31'd0};
        end else begin
            norm_done = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = ALIGN;
            end
            ALIGN: state_nx = ADD;
            ADD:   state_nx = special ? DONE : NORM;
            NORM:  state_nx = norm_done ? DONE : NORM;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shared datapath registers; each state updates only its own stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            exp_r   <= '0;
            sig_a_r <= '0;
            sig_b_r <= '0;
            sum_r   <= '0;
            sign_r  <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a <= fp_unpack(a, 1'b0);
                        op_b <= fp_unpack(b, sub);
                    end
                end
                ALIGN: begin
                    exp_r   <= al_exp;
                    sig_a_r <= al_sig_a;
                    sig_b_r <= al_sig_b;
                end
                ADD: begin
                    if (special) begin
                        result <= special_val;
                    end else begin
                        sum_r  <= add_sum;
                        sign_r <= add_sign;
                    end
                end
                NORM: begin
                    if (norm_done) begin
                        result <= norm_res;
                    end else begin
                        sum_r <= sum_r << 1;
                        exp_r <= exp_r - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_seq.sv
// Scoreboard bench for fp_add_seq: expected result and latency are queued
// at the accept edge and compared when out_valid appears.
module tb_fp_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    always #5 clk = ~clk;

    fp_add_seq #(.MAX_SHIFT(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp_v);
        end
    endtask

    // Drive one pair, queue its expectation, wait for the result, optionally
    // hold back-pressure (with a new pair already offered), then handshake.
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic ts, input logic [31:0] er, input int el, input int bp,
                         input logic hold, input logic [31:0] na, input logic [31:0] nb);
        int          n;
        int          lat;
        logic [31:0] held;
        exp_t        e;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        sb_q.push_back('{er, el});
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        held = result;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_lat"}, 32'(lat + 1), 32'(e.lat));
            chk({tag, "_res"}, held, e.res);
        end else begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end
        if (hold) begin
            a = na; b = nb; sub = 1'b0; in_valid = 1'b1;
        end
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_bp_res"}, result, held);
            chk({tag, "_bp_inrdy"}, {31'd0, in_ready}, 32'd0);
            chk({tag, "_bp_valid"}, {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_hs_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_hs_inrdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inrdy", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res", result, 32'h0);
        rst = 1'b0;

        do_op("carry",    32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4, 0, 1'b0, 0, 0);
        do_op("lshift2",  32'h3F800000, 32'hBF400000, 1'b0, 32'h3E800000, 6, 0, 1'b0, 0, 0);
        do_op("clamp30",  32'h3FC00000, 32'h30800000, 1'b0, 32'h3FC00000, 4, 0, 1'b0, 0, 0);
        do_op("sub_eq",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4, 0, 1'b0, 0, 0);
        do_op("inf_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3, 0, 1'b0, 0, 0);
        do_op("ovf",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4, 0, 1'b0, 0, 0);
        do_op("two_three",32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 4, 0, 1'b0, 0, 0);
        do_op("sub_half", 32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 5, 0, 1'b0, 0, 0);
        do_op("neg_res",  32'h3F400000, 32'h3F800000, 1'b1, 32'hBE800000, 6, 0, 1'b0, 0, 0);
        do_op("nan_in",   32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3, 0, 1'b0, 0, 0);
        do_op("inf_pass", 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3, 0, 1'b0, 0, 0);
        do_op("nzero",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3, 0, 1'b0, 0, 0);
        do_op("nz_subpz", 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3, 0, 1'b0, 0, 0);
        do_op("pz_nz",    32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3, 0, 1'b0, 0, 0);
        do_op("denorm",   32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4, 0, 1'b0, 0, 0);
        do_op("uflow",    32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4, 0, 1'b0, 0, 0);
        do_op("trunc",    32'h3F800001, 32'h3F800000, 1'b0, 32'h40000000, 4, 0, 1'b0, 0, 0);
        do_op("clamp24",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4, 0, 1'b0, 0, 0);

        // Back-pressure with the next pair already offered during the hold.
        do_op("bp",       32'h3F800000, 32'hBF400000, 1'b0, 32'h3E800000, 6, 10, 1'b1,
              32'h40000000, 32'h40400000);
        do_op("bp_next",  32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 4, 0, 1'b0, 0, 0);

        // Reset while in NORM: the in-flight operation vanishes.
        @(negedge clk);
        a = 32'h3F800000; b = 32'hBF400000; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_inrdy", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_res", result, 32'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        do_op("after_rst", 32'h3F800000, 32'hBF400000, 1'b0, 32'h3E800000, 6, 0, 1'b0, 0, 0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
